// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_param
// Brief    : Parametrised full-duplex UART, 16x oversampled RX with majority vote.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int BAUD_DIV  = 326,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clkInput,
    input  logic                 rstInput,
    input  logic                 rxInput,
    output logic                 txOutput,
    input  logic [DATA_BITS-1:0] sendData,
    input  logic                 sendStart,
    output logic                 sendReady,
    output logic                 sendCompFlag,
    output logic [DATA_BITS-1:0] recvData,
    output logic                 recvCompFlag,
    output logic                 recvParityErr,
    output logic                 recvFrameErr
);

    localparam int                 c_DIV_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(BAUD_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [3:0]         c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;

    function automatic logic parityOf(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    // ---------------- TX ----------------
    txState_t               r_txState, w_txStateNext;
    logic [c_DIV_W-1:0]     r_txDiv, w_txDivNext;
    logic [3:0]             r_txSample, w_txSampleNext;
    logic [3:0]             r_txBitCnt, w_txBitCntNext;
    logic [DATA_BITS-1:0]   r_txShift, w_txShiftNext;
    logic                   r_txParity, w_txParityNext;
    logic                   r_txOut, w_txOutNext;
    logic                   r_sendReady, w_sendReadyNext;
    logic                   r_sendComp, w_sendCompNext;
    logic                   w_txBitEnd;

    assign w_txBitEnd = (r_txDiv == c_DIV_MAX) && (r_txSample == 4'hF);

    always_comb begin
        w_txStateNext   = r_txState;
        w_txDivNext     = r_txDiv;
        w_txSampleNext  = r_txSample;
        w_txBitCntNext  = r_txBitCnt;
        w_txShiftNext   = r_txShift;
        w_txParityNext  = r_txParity;
        w_txOutNext     = r_txOut;
        w_sendReadyNext = r_sendReady;
        w_sendCompNext  = 1'b0;
        if (r_txState != TX_IDLE) begin
            if (r_txDiv == c_DIV_MAX) begin
                w_txDivNext    = '0;
                w_txSampleNext = r_txSample + 4'd1;
            end else begin
                w_txDivNext = r_txDiv + c_DIV_ONE;
            end
        end
        case (r_txState)
            TX_IDLE: begin
                // Divider restarts here so every bit is exactly 16*BAUD_DIV clocks.
                if (sendStart && r_sendReady) begin
                    w_txStateNext   = TX_START;
                    w_txShiftNext   = sendData;
                    w_txParityNext  = parityOf(sendData);
                    w_txOutNext     = 1'b0;
                    w_sendReadyNext = 1'b0;
                    w_txDivNext     = '0;
                    w_txSampleNext  = 4'd0;
                    w_txBitCntNext  = 4'd0;
                end
            end
            TX_START: begin
                if (w_txBitEnd) begin
                    w_txStateNext  = TX_DATA;
                    w_txOutNext    = r_txShift[0];
                    w_txShiftNext  = {1'b0, r_txShift[DATA_BITS-1:1]};
                    w_txBitCntNext = 4'd0;
                end
            end
            TX_DATA: begin
                if (w_txBitEnd) begin
                    if (r_txBitCnt == c_LAST_DATA) begin
                        w_txBitCntNext = 4'd0;
                        if (PARITY != 0) begin
                            w_txStateNext = TX_PARITY;
                            w_txOutNext   = r_txParity;
                        end else begin
                            w_txStateNext = TX_STOP;
                            w_txOutNext   = 1'b1;
                        end
                    end else begin
                        w_txOutNext    = r_txShift[0];
                        w_txShiftNext  = {1'b0, r_txShift[DATA_BITS-1:1]};
                        w_txBitCntNext = r_txBitCnt + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_txBitEnd) begin
                    w_txStateNext  = TX_STOP;
                    w_txOutNext    = 1'b1;
                    w_txBitCntNext = 4'd0;
                end
            end
            TX_STOP: begin
                if (w_txBitEnd) begin
                    if (r_txBitCnt == c_LAST_STOP) begin
                        w_txStateNext   = TX_IDLE;
                        w_sendCompNext  = 1'b1;
                        w_sendReadyNext = 1'b1;
                        w_txOutNext     = 1'b1;
                    end else begin
                        w_txBitCntNext = r_txBitCnt + 4'd1;
                    end
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clkInput) begin
        if (rstInput) begin
            r_txState   <= TX_IDLE;
            r_txDiv     <= '0;
            r_txSample  <= 4'd0;
            r_txBitCnt  <= 4'd0;
            r_txShift   <= '0;
            r_txParity  <= 1'b0;
            r_txOut     <= 1'b1;
            r_sendReady <= 1'b1;
            r_sendComp  <= 1'b0;
        end else begin
            r_txState   <= w_txStateNext;
            r_txDiv     <= w_txDivNext;
            r_txSample  <= w_txSampleNext;
            r_txBitCnt  <= w_txBitCntNext;
            r_txShift   <= w_txShiftNext;
            r_txParity  <= w_txParityNext;
            r_txOut     <= w_txOutNext;
            r_sendReady <= w_sendReadyNext;
            r_sendComp  <= w_sendCompNext;
        end
    end

    assign txOutput     = r_txOut;
    assign sendReady    = r_sendReady;
    assign sendCompFlag = r_sendComp;

    // ---------------- RX ----------------
    rxState_t               r_rxState, w_rxStateNext;
    logic                   r_rxSync1, r_rxSync2;
    logic [c_DIV_W-1:0]     r_rxTickCnt;
    logic [3:0]             r_rxSample, w_rxSampleNext;
    logic [1:0]             r_rxVote, w_rxVoteNext;
    logic [3:0]             r_rxBitCnt, w_rxBitCntNext;
    logic [DATA_BITS-1:0]   r_rxShift, w_rxShiftNext;
    logic                   r_rxParBit, w_rxParBitNext;
    logic                   r_rxStopBit, w_rxStopBitNext;
    logic [DATA_BITS-1:0]   r_recvData, w_recvDataNext;
    logic                   r_recvComp, w_recvCompNext;
    logic                   r_recvParErr, w_recvParErrNext;
    logic                   r_recvFrameErr, w_recvFrameErrNext;
    logic                   w_tick, w_rxMaj;

    assign w_tick  = (r_rxTickCnt == c_DIV_MAX);
    // Samples 7 and 8 are held; sample 9 is the live line at the count-9 tick.
    assign w_rxMaj = (r_rxVote[0] & r_rxVote[1]) | (r_rxVote[0] & r_rxSync2) | (r_rxVote[1] & r_rxSync2);

    always_comb begin
        w_rxStateNext      = r_rxState;
        w_rxSampleNext     = r_rxSample;
        w_rxVoteNext       = r_rxVote;
        w_rxBitCntNext     = r_rxBitCnt;
        w_rxShiftNext      = r_rxShift;
        w_rxParBitNext     = r_rxParBit;
        w_rxStopBitNext    = r_rxStopBit;
        w_recvDataNext     = r_recvData;
        w_recvParErrNext   = r_recvParErr;
        w_recvFrameErrNext = r_recvFrameErr;
        w_recvCompNext     = 1'b0;
        if (w_tick && (r_rxState != RX_IDLE) && (r_rxState != RX_WAIT_HIGH)) begin
            w_rxSampleNext = r_rxSample + 4'd1;
            if (r_rxSample == 4'd7) w_rxVoteNext[0] = r_rxSync2;
            if (r_rxSample == 4'd8) w_rxVoteNext[1] = r_rxSync2;
        end
        case (r_rxState)
            RX_IDLE: begin
                if (w_tick && !r_rxSync2) begin
                    w_rxStateNext  = RX_START;
                    w_rxSampleNext = 4'd0;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if ((r_rxSample == 4'd9) && w_rxMaj) begin
                        w_rxStateNext = RX_IDLE;
                    end else if (r_rxSample == 4'd15) begin
                        w_rxStateNext  = RX_DATA;
                        w_rxBitCntNext = 4'd0;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    if (r_rxSample == 4'd9) w_rxShiftNext = {w_rxMaj, r_rxShift[DATA_BITS-1:1]};
                    if (r_rxSample == 4'd15) begin
                        if (r_rxBitCnt == c_LAST_DATA) begin
                            w_rxStateNext = (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            w_rxBitCntNext = r_rxBitCnt + 4'd1;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (w_tick) begin
                    if (r_rxSample == 4'd9)  w_rxParBitNext = w_rxMaj;
                    if (r_rxSample == 4'd15) w_rxStateNext  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (r_rxSample == 4'd9) w_rxStopBitNext = w_rxMaj;
                    // Complete mid-stop-bit so the next start edge is never missed.
                    if (r_rxSample == 4'd10) begin
                        w_recvDataNext     = r_rxShift;
                        w_recvParErrNext   = (PARITY != 0) && (r_rxParBit != parityOf(r_rxShift));
                        w_recvFrameErrNext = !r_rxStopBit;
                        w_recvCompNext     = 1'b1;
                        w_rxStateNext      = r_rxStopBit ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rxSync2) w_rxStateNext = RX_IDLE;
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clkInput) begin
        if (rstInput) begin
            r_rxSync1      <= 1'b1;
            r_rxSync2      <= 1'b1;
            r_rxTickCnt    <= '0;
            r_rxState      <= RX_IDLE;
            r_rxSample     <= 4'd0;
            r_rxVote       <= 2'b00;
            r_rxBitCnt     <= 4'd0;
            r_rxShift      <= '0;
            r_rxParBit     <= 1'b0;
            r_rxStopBit    <= 1'b0;
            r_recvData     <= '0;
            r_recvComp     <= 1'b0;
            r_recvParErr   <= 1'b0;
            r_recvFrameErr <= 1'b0;
        end else begin
            r_rxSync1      <= rxInput;
            r_rxSync2      <= r_rxSync1;
            r_rxTickCnt    <= w_tick ? '0 : r_rxTickCnt + c_DIV_ONE;
            r_rxState      <= w_rxStateNext;
            r_rxSample     <= w_rxSampleNext;
            r_rxVote       <= w_rxVoteNext;
            r_rxBitCnt     <= w_rxBitCntNext;
            r_rxShift      <= w_rxShiftNext;
            r_rxParBit     <= w_rxParBitNext;
            r_rxStopBit    <= w_rxStopBitNext;
            r_recvData     <= w_recvDataNext;
            r_recvComp     <= w_recvCompNext;
            r_recvParErr   <= w_recvParErrNext;
            r_recvFrameErr <= w_recvFrameErrNext;
        end
    end

    assign recvData      = r_recvData;
    assign recvCompFlag  = r_recvComp;
    assign recvParityErr = r_recvParErr;
    assign recvFrameErr  = r_recvFrameErr;

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core_param
// Brief    : Self-checking bench; four UART instances (none/even/odd parity, 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sendData;
    logic [3:0] start, loop, rxDrive, rxLine, txLine;
    logic [3:0] sendReady, sendComp, recvComp, parErr, frameErr;
    logic [7:0] recvData [4];

    int   nCompared = 0;
    int   nMis      = 0;
    int   cycle     = 0;
    int   sendCount [4] = '{0, 0, 0, 0};
    rec_t expQ[$];
    rec_t obsQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign rxLine = (loop & txLine) | (~loop & rxDrive);

    uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) uNone (
        .clkInput(clk), .rstInput(rst), .rxInput(rxLine[0]), .txOutput(txLine[0]),
        .sendData(sendData), .sendStart(start[0]), .sendReady(sendReady[0]),
        .sendCompFlag(sendComp[0]), .recvData(recvData[0]), .recvCompFlag(recvComp[0]),
        .recvParityErr(parErr[0]), .recvFrameErr(frameErr[0]));
    uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) uEven (
        .clkInput(clk), .rstInput(rst), .rxInput(rxLine[1]), .txOutput(txLine[1]),
        .sendData(sendData), .sendStart(start[1]), .sendReady(sendReady[1]),
        .sendCompFlag(sendComp[1]), .recvData(recvData[1]), .recvCompFlag(recvComp[1]),
        .recvParityErr(parErr[1]), .recvFrameErr(frameErr[1]));
    uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) uOdd (
        .clkInput(clk), .rstInput(rst), .rxInput(rxLine[2]), .txOutput(txLine[2]),
        .sendData(sendData), .sendStart(start[2]), .sendReady(sendReady[2]),
        .sendCompFlag(sendComp[2]), .recvData(recvData[2]), .recvCompFlag(recvComp[2]),
        .recvParityErr(parErr[2]), .recvFrameErr(frameErr[2]));
    uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) uTwoStop (
        .clkInput(clk), .rstInput(rst), .rxInput(rxLine[3]), .txOutput(txLine[3]),
        .sendData(sendData), .sendStart(start[3]), .sendReady(sendReady[3]),
        .sendCompFlag(sendComp[3]), .recvData(recvData[3]), .recvCompFlag(recvComp[3]),
        .recvParityErr(parErr[3]), .recvFrameErr(frameErr[3]));

    // Capture every completion; the tasks compare against the expected queue.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (recvComp[i] === 1'b1)
                obsQ.push_back(rec_t'{idx: 2'(i), data: recvData[i], perr: parErr[i], ferr: frameErr[i]});
            if (sendComp[i] === 1'b1) sendCount[i] = sendCount[i] + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic rec_t popObs();
        if (obsQ.size() == 0) return '1;
        return obsQ.pop_front();
    endfunction

    function automatic rec_t popExp();
        if (expQ.size() == 0) return '0;
        return expQ.pop_front();
    endfunction

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitSend(input int idx, input int maxCyc, output int tDone);
        int k = 0;
        while (sendComp[idx] !== 1'b1 && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        tDone = cycle;
        if (sendComp[idx] !== 1'b1) begin
            nCompared++;
            nMis++;
            $display("FAIL sendComp_timeout dut%0d: got no pulse, required one within %0d clocks", idx, maxCyc);
        end
    endtask

    task automatic waitObs(input int n, input int maxCyc);
        int k = 0;
        while (obsQ.size() < n && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        if (obsQ.size() < n) begin
            nCompared++;
            nMis++;
            $display("FAIL recvComp_timeout: got %0d completions, required %0d", obsQ.size(), n);
        end
    endtask

    task automatic sendFrame(input int idx, input logic [7:0] data, output int tAcc);
        sendData   = data;
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        tAcc       = cycle;
    endtask

    task automatic driveFrame(input int idx, input logic [7:0] data, input logic hasPar,
                              input logic parBit, input logic stopBit);
        rxDrive[idx] = 1'b0;
        waitCyc(64);
        for (int i = 0; i < 8; i++) begin
            rxDrive[idx] = data[i];
            waitCyc(64);
        end
        if (hasPar) begin
            rxDrive[idx] = parBit;
            waitCyc(64);
        end
        rxDrive[idx] = stopBit;
        waitCyc(64);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; sendData = '0; rxDrive = '1; loop = '1;
        waitCyc(3);
        rst = 1'b0;
        @(negedge clk);
        nCompared++; if (txLine !== 4'hF) begin nMis++; $display("FAIL reset_txOutput: got %b, required 1111", txLine); end
        nCompared++; if (sendReady !== 4'hF) begin nMis++; $display("FAIL reset_sendReady: got %b, required 1111", sendReady); end
        nCompared++; if ((sendComp | recvComp) !== 4'h0) begin nMis++; $display("FAIL reset_flags: got send %b recv %b, required 0", sendComp, recvComp); end
        nCompared++; if ({recvData[0], recvData[3]} !== 16'h0) begin nMis++; $display("FAIL reset_recvData: got %h %h, required 00", recvData[0], recvData[3]); end
        nCompared++; if ((parErr | frameErr) !== 4'h0) begin nMis++; $display("FAIL reset_errors: got par %b frame %b, required 0", parErr, frameErr); end
    endtask

    task automatic test_loopback();
        int   tA, tHigh, tC, k;
        rec_t got, exp;
        expQ.push_back(rec_t'{idx: 2'd0, data: 8'hC9, perr: 1'b0, ferr: 1'b0});
        sendFrame(0, 8'hC9, tA);
        nCompared++; if ({txLine[0], sendReady[0]} !== 2'b00) begin nMis++; $display("FAIL accept_state: got tx/ready %b%b, required 00", txLine[0], sendReady[0]); end
        k = 0;
        while (txLine[0] === 1'b0 && k < 200) begin @(negedge clk); k++; end
        tHigh = cycle;
        nCompared++; if (tHigh - tA !== 64) begin nMis++; $display("FAIL start_bit_len: got %0d clocks, required 64", tHigh - tA); end
        waitSend(0, 1000, tC);
        nCompared++; if (tC - tA !== 640) begin nMis++; $display("FAIL frame_len: got %0d clocks, required 640", tC - tA); end
        nCompared++; if (sendReady[0] !== 1'b1) begin nMis++; $display("FAIL ready_after_comp: got %b, required 1", sendReady[0]); end
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL loopback_C9: got %h, required %h", got, exp); end
        waitCyc(64);
        nCompared++; if (obsQ.size() !== 0) begin nMis++; $display("FAIL single_recv_pulse: got %0d extra, required 0", obsQ.size()); end
    endtask

    task automatic test_parity();
        int   tA, tC;
        rec_t got, exp;
        for (int k = 1; k <= 2; k++) begin
            expQ.push_back(rec_t'{idx: 2'(k), data: 8'h07, perr: 1'b0, ferr: 1'b0});
            sendFrame(k, 8'h07, tA);
            waitCyc(608);
            nCompared++;
            if (txLine[k] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                nMis++; $display("FAIL parity_bit_dut%0d: got %b, required %b", k, txLine[k], (k == 1));
            end
            waitSend(k, 200, tC);
            waitObs(1, 200);
            got = popObs(); exp = popExp();
            nCompared++; if (got !== exp) begin nMis++; $display("FAIL parity_loop_dut%0d: got %h, required %h", k, got, exp); end
        end
    endtask

    task automatic test_parity_error();
        rec_t got, exp;
        loop[1] = 1'b0;
        expQ.push_back(rec_t'{idx: 2'd1, data: 8'hA5, perr: 1'b1, ferr: 1'b0});
        driveFrame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL bad_parity_A5: got %h, required %h", got, exp); end
        expQ.push_back(rec_t'{idx: 2'd1, data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        driveFrame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL parity_clear_5A: got %h, required %h", got, exp); end
        loop[1] = 1'b1;
    endtask

    task automatic test_frame_error();
        rec_t got, exp;
        loop[0] = 1'b0;
        expQ.push_back(rec_t'{idx: 2'd0, data: 8'h81, perr: 1'b0, ferr: 1'b1});
        driveFrame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        waitCyc(1000);
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL frame_err_81: got %h, required %h", got, exp); end
        nCompared++; if (obsQ.size() !== 0) begin nMis++; $display("FAIL break_pulses: got %0d, required 0", obsQ.size()); end
        rxDrive[0] = 1'b1;
        waitCyc(128);
        expQ.push_back(rec_t'{idx: 2'd0, data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        driveFrame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL recover_3C: got %h, required %h", got, exp); end
        loop[0] = 1'b1;
    endtask

    task automatic test_glitch();
        rec_t got, exp;
        loop[0] = 1'b0;
        rxDrive[0] = 1'b0;
        waitCyc(12);
        rxDrive[0] = 1'b1;
        waitCyc(3 * 64);
        nCompared++; if (obsQ.size() !== 0) begin nMis++; $display("FAIL glitch_pulse: got %0d completions, required 0", obsQ.size()); end
        expQ.push_back(rec_t'{idx: 2'd0, data: 8'h96, perr: 1'b0, ferr: 1'b0});
        driveFrame(0, 8'h96, 1'b0, 1'b0, 1'b1);
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL after_glitch_96: got %h, required %h", got, exp); end
        loop[0] = 1'b1;
    endtask

    task automatic test_back_to_back();
        int   tA1, tC1, tA2, tC2, s0;
        rec_t got, exp;
        s0 = sendCount[3];
        expQ.push_back(rec_t'{idx: 2'd3, data: 8'h3A, perr: 1'b0, ferr: 1'b0});
        expQ.push_back(rec_t'{idx: 2'd3, data: 8'hC5, perr: 1'b0, ferr: 1'b0});
        sendData = 8'h3A;
        start[3] = 1'b1;
        @(negedge clk);
        tA1 = cycle;
        waitSend(3, 1000, tC1);
        nCompared++; if (tC1 - tA1 !== 704) begin nMis++; $display("FAIL b2b_frame1_len: got %0d, required 704", tC1 - tA1); end
        sendData = 8'hC5;
        @(negedge clk);
        tA2 = cycle;
        start[3] = 1'b0;
        nCompared++; if ({txLine[3], sendReady[3]} !== 2'b00) begin nMis++; $display("FAIL b2b_accept: got tx/ready %b%b, required 00", txLine[3], sendReady[3]); end
        waitSend(3, 1000, tC2);
        nCompared++; if (tC2 - tA2 !== 704) begin nMis++; $display("FAIL b2b_frame2_len: got %0d, required 704", tC2 - tA2); end
        waitCyc(200);
        nCompared++; if (sendCount[3] - s0 !== 2) begin nMis++; $display("FAIL b2b_comp_count: got %0d, required 2", sendCount[3] - s0); end
        waitObs(2, 200);
        for (int k = 0; k < 2; k++) begin
            got = popObs(); exp = popExp();
            nCompared++; if (got !== exp) begin nMis++; $display("FAIL b2b_recv%0d: got %h, required %h", k, got, exp); end
        end
    endtask

    task automatic test_reset_mid_tx();
        int   tA, tC, sc;
        rec_t got, exp;
        sc = sendCount[0];
        sendFrame(0, 8'h00, tA);
        waitCyc(340);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nCompared++; if ({txLine[0], sendReady[0]} !== 2'b11) begin nMis++; $display("FAIL reset_mid_tx: got tx/ready %b%b, required 11", txLine[0], sendReady[0]); end
        waitCyc(800);
        nCompared++; if (sendCount[0] !== sc || obsQ.size() !== 0) begin
            nMis++; $display("FAIL reset_no_pulse: got %0d send / %0d recv pulses, required 0 / 0", sendCount[0] - sc, obsQ.size());
        end
        expQ.push_back(rec_t'{idx: 2'd0, data: 8'h55, perr: 1'b0, ferr: 1'b0});
        sendFrame(0, 8'h55, tA);
        waitSend(0, 1000, tC);
        nCompared++; if (tC - tA !== 640) begin nMis++; $display("FAIL post_reset_len: got %0d, required 640", tC - tA); end
        waitObs(1, 200);
        got = popObs(); exp = popExp();
        nCompared++; if (got !== exp) begin nMis++; $display("FAIL post_reset_55: got %h, required %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity();
        test_parity_error();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART and successor to uart_main, in the same clock domain as the rest of the design.
- Configurable data width, parity mode, stop-bit count and baud divider.
- RX uses 16x oversampling with 3-sample majority vote and reports parity and framing errors.
- Both directions use active-high one-clock strobes; TX adds a ready/start handshake for back-to-back frames.

Parameters:
- BAUD_DIV, 326, clocks per oversample tick; one bit period = 16*BAUD_DIV clocks (minimum 2).
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, TX stop bits (1 or 2); RX checks the first stop bit only.

Ports:
- clkInput  in  1  system clock; all logic on the rising edge.
- rstInput  in  1  synchronous active-high reset.
- rxInput  in  1  serial input, asynchronous, idle high.
- txOutput  out  1  serial output, registered, idle high.
- sendData  in  DATA_BITS  TX data, captured on acceptance.
- sendStart  in  1  TX request; accepted on an edge where sendStart && sendReady.
- sendReady  out  1  TX idle and able to accept.
- sendCompFlag  out  1  one-clock pulse at TX frame end.
- recvData  out  DATA_BITS  last received data, held until the next completion.
- recvCompFlag  out  1  one-clock pulse when recvData/error flags update.
- recvParityErr  out  1  parity mismatch on the last frame; 0 when PARITY=0.
- recvFrameErr  out  1  first stop bit sampled low on the last frame.

Behaviour:
- Reset (synchronous, edge with rstInput=1):
  - outputs: txOutput=1, sendReady=1, sendCompFlag=0, recvData=0, recvCompFlag=0, both error flags 0;
  - state: both FSMs to IDLE, all counters 0, RX synchroniser flops preset to 1;
  - mid-frame: frame abandoned and no completion pulse issued.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Own divider, restarted at acceptance, so every bit lasts exactly 16*BAUD_DIV clocks.
  - Acceptance at edge E0: latch sendData, sendReady=0, txOutput=0 (start bit) from E0.
  - Then DATA_BITS data bits LSB first, then the parity bit if PARITY!=0, then STOP_BITS high bits.
  - Parity bit: even mode = XOR of the data bits; odd mode = its inverse.
  - Frame length F = 1+DATA_BITS+(PARITY?1:0)+STOP_BITS bits.
  - At edge E0+16*BAUD_DIV*F: sendCompFlag=1 for one clock, sendReady=1, FSM returns to IDLE.
  - sendStart is ignored while sendReady=0.
  - A request held high at the sendCompFlag edge is accepted on the next edge, giving back-to-back frames with no extra idle bit.
- RX front end:
  - 2-flop synchroniser on rxInput.
  - Free-running tick counter 0..BAUD_DIV-1; tick asserted on wrap.
  - 4-bit sample counter per bit (0..15).
- RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
  - IDLE: on a tick with the synchronised line low, go to START with the sample counter at 0.
  - Every state samples at counts 7, 8 and 9 and takes the majority value.
  - START: majority 1 is a glitch; return to IDLE with no pulse. Majority 0 enters DATA after count 15.
  - DATA: DATA_BITS bits shifted in LSB first; then PARITY (if enabled), else STOP.
  - PARITY: majority compared against the parity computed over the received data.
  - STOP: on the tick after the count-9 sample (mid-bit, not end of bit):
    - update recvData, recvParityErr and recvFrameErr;
    - pulse recvCompFlag;
    - go to IDLE if the stop bit was 1, else WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is seen high (break/framing recovery), then IDLE.
  - Errors still deliver data. Error flags hold their value until the next completion.
- TX and RX are fully independent; simultaneous activity is allowed.

Test Plan:
All tests use BAUD_DIV=4 (64 clocks/bit), DATA_BITS=8.
1. Loopback (txOutput->rxInput), PARITY=0, STOP_BITS=1, sendData=8'hC9 accepted at E0 -> txOutput low E0..E0+63; sendCompFlag at E0+640; recvCompFlag once; recvData=8'hC9; both errors 0.
2. PARITY=1, send 8'h07 -> parity bit on line = 1, loopback recvParityErr=0. Repeat with PARITY=2 -> parity bit = 0, recvParityErr=0.
3. Bench-driven frame 8'hA5, PARITY=1, parity bit forced wrong -> recvData=8'hA5, recvParityErr=1, recvFrameErr=0. A following good frame clears recvParityErr.
4. Stop bit driven low, then line held low 1000 clocks, then high, then a valid 8'h3C frame -> first completion has recvFrameErr=1; no further pulse while low; second completion recvData=8'h3C, recvFrameErr=0.
5. rxInput low pulse of 12 clocks -> no recvCompFlag, FSM back in IDLE. STOP_BITS=2 with sendStart held high -> two frames back-to-back, 704 clocks apart, each with one sendCompFlag.
6. rstInput asserted one clock during TX data bit 4 -> txOutput=1 and sendReady=1 after that edge, no sendCompFlag. A new 8'h55 request is then sent correctly in loopback.
